// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit
//  Description : Multi-cycle signed multiply / divide unit beside the execute
//                stage. Radix-2 shift-add multiply and non-restoring divide,
//                one iteration per clock, fixed 33-edge latency from the
//                accepting edge to the edge that enters DONE.
//
//  Ports
//    clock           in   processor clock, rising-edge active
//    reset           in   synchronous, active-high reset
//    data_operandA   in   multiplicand / dividend (two's complement)
//    data_operandB   in   multiplier / divisor   (two's complement)
//    ctrl_MULT       in   one-cycle multiply start pulse (wins over ctrl_DIV)
//    ctrl_DIV        in   one-cycle divide start pulse
//    data_result     out  low half of product, or quotient
//    data_exception  out  overflow / divide-by-zero flag for data_result
//    data_resultRDY  out  single-cycle completion strobe (DONE state)
//    busy            out  high while an operation is iterating
//
//  Revision    : 1.0  initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH = 32,  // only 32 is supported
  parameter int ITER  = 32   // must equal WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // State
  //   hi_q   : multiply -> upper product half (bits WIDTH-1:0 used)
  //            divide   -> signed partial remainder (WIDTH+2 bits, since the
  //                        non-restoring remainder spans [-D, D) and 2R+D
  //                        needs one bit beyond WIDTH+1)
  //   lo_q   : multiply -> multiplier shifting out / product lower half
  //            divide   -> dividend shifting out / quotient shifting in
  //   opnd_q : multiplicand magnitude or divisor magnitude
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH+1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] opnd_q,   opnd_d;
  logic             neg_q,    neg_d;
  logic             dz_q,     dz_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             exc_q,    exc_d;

  // Operand magnitudes; |most negative| is representable as an unsigned value.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_sign_diff;

  assign w_abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  assign w_sign_diff = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];

  // Multiply iteration: conditional add, then shift {carry, hi, lo} right.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide iteration: shift {R, Q} left, then subtract if R was non-negative,
  // add if negative. The new quotient bit is 1 when the new R is non-negative,
  // which gives the same quotient as restoring division without a fix-up.
  logic [WIDTH+1:0] w_div_shift;
  logic [WIDTH+1:0] w_div_rem;
  assign w_div_shift = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
  assign w_div_rem   = hi_q[WIDTH+1] ? (w_div_shift + {2'b00, opnd_q})
                                     : (w_div_shift - {2'b00, opnd_q});

  // Final result forming from the completed iteration registers.
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_prod_s;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quot_s;

  assign w_prod_u  = {hi_q[WIDTH-1:0], lo_q};
  assign w_prod_s  = neg_q ? (~w_prod_u + 1'b1) : w_prod_u;
  // Fits in signed WIDTH bits only if the top WIDTH+1 bits are all equal.
  assign w_mul_ovf = ~((&w_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_s[2*WIDTH-1:WIDTH-1]));
  assign w_quot_s  = neg_q ? (~lo_q + 1'b1) : lo_q;

  logic w_start_mul;
  logic w_start_div;
  assign w_start_mul = ctrl_MULT;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;

    case (state_q)
      c_IDLE, c_DONE: begin
        state_d = c_IDLE;
        if (w_start_mul) begin
          state_d = c_MUL;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = w_abs_b;
          opnd_d  = w_abs_a;
          neg_d   = w_sign_diff;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
        end else if (w_start_div) begin
          state_d = c_DIV;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = w_abs_a;
          opnd_d  = w_abs_b;
          neg_d   = w_sign_diff;
          dz_d    = (data_operandB == '0);
          ovf_d   = (data_operandA == c_MOST_NEG) && (data_operandB == c_ALL_ONES);
        end
      end

      c_MUL: begin
        if (cnt_q == CNT_W'(ITER)) begin
          state_d = c_DONE;
          cnt_d   = '0;
          res_d   = w_prod_s[WIDTH-1:0];
          exc_d   = w_mul_ovf;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          hi_d  = {2'b00, w_mul_sum[WIDTH:1]};
          lo_d  = {w_mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end

      c_DIV: begin
        if (cnt_q == CNT_W'(ITER)) begin
          state_d = c_DONE;
          cnt_d   = '0;
          if (dz_q) begin
            res_d = '0;
            exc_d = 1'b1;
          end else if (ovf_q) begin
            res_d = c_MOST_NEG;
            exc_d = 1'b1;
          end else begin
            res_d = w_quot_s;
            exc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          hi_d  = w_div_rem;
          lo_d  = {lo_q[WIDTH-2:0], ~w_div_rem[WIDTH+1]};
        end
      end

      default: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == c_DONE);
  assign busy           = (state_q == c_MUL) || (state_q == c_DIV);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Self-checking bench for multdiv_unit. Vector table plus
//                reference-model random ops, expected results queued at
//                issue and compared when data_resultRDY strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[16];
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = !((p[63:31] == 33'h0) || (p[63:31] == 33'h1_FFFF_FFFF));
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  // Drive a start at the current negedge; it is sampled at the next posedge
  // (edge N). Returns 1 ns after edge N with the start removed and the
  // operands scrambled.
  task automatic drive(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Full operation with timing checks: busy for cycles after edges N..N+32,
  // RDY (and not busy) in the cycle after edge N+33.
  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e);
    bit bad;
    exp_t x;
    bad = 1'b0;
    x.r = r;
    x.e = e;
    exp_q.push_back(x);
    drive(m, d, a, b);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clock);
      if (!(busy === 1'b1 && data_resultRDY === 1'b0)) bad = 1'b1;
    end
    @(negedge clock);
    chk("busy_window", {31'b0, bad}, 32'h0);
    chk("rdy_strobe", {30'b0, data_resultRDY, busy}, 32'h2);
  endtask

  initial begin
    int          n;
    int          rdy_before;
    bit          m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
    exp_t        x;

    //            m     d     A              B              result         exc
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0006, 32'h0000_0003, 32'h0000_0012, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    // Result monitor / scoreboard.
    fork
      forever begin
        @(negedge clock);
        if (reset === 1'b0 && data_resultRDY === 1'b1) begin
          rdy_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy: got result %h with no operation pending at %0t",
                     data_result, $time);
          end else begin
            x = exp_q.pop_front();
            chk("result", data_result, x.r);
            chk("exception", {31'b0, data_exception}, {31'b0, x.e});
          end
        end
      end
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_exception", {31'b0, data_exception}, 32'h0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    // Table: even entries issued back-to-back in the DONE cycle, odd entries
    // after some idle cycles.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) repeat (2) @(negedge clock);
      do_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].e);
    end

    // Start ignored while busy: DIV pulse on edge N+5 of a multiply.
    repeat (2) @(negedge clock);
    rdy_before = rdy_cnt;
    x.r = 32'h0001_2340;
    x.e = 1'b0;
    exp_q.push_back(x);
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010);
    for (int k = 0; k < 5; k++) @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'h0000_0009;
    data_operandB = 32'h0000_0003;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    n = 5;
    while (n < 60 && data_resultRDY !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    chk("ignored_start_latency", n, 34);
    // New multiply issued in the RDY cycle.
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0);
    repeat (40) @(negedge clock);
    chk("ignored_start_rdy_count", rdy_cnt - rdy_before, 2);

    // Reset asserted at edge N+10 of a multiply.
    rdy_before = rdy_cnt;
    drive(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
    for (int k = 0; k < 10; k++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_result", data_result, 32'h0);
    chk("midreset_exception", {31'b0, data_exception}, 32'h0);
    chk("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("aborted_rdy_count", rdy_cnt - rdy_before, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FF00, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      m = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(0, 15) - 7;
      if (i % 4 == 2) a = a >>> 16;
      model(m, a, b, r, e);
      if (i % 3 == 0) @(negedge clock);
      do_op(m, !m, a, b, r, e);
    end

    repeat (2) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
